// File: rtl/uart_cmd_pkg.sv
// Shared constants, FSM state encoding and helpers for the UART command parser.
package uart_cmd_pkg;

  localparam logic [7:0] HDR        = 8'hA5;
  localparam logic [7:0] CMD_MODE   = 8'h01;
  localparam logic [7:0] CMD_FACTOR = 8'h02;

  localparam logic [2:0] MODE_555  = 3'b001;
  localparam logic [2:0] MODE_SINE = 3'b010;

  typedef enum logic [2:0] {
    StIdle,
    StGetCmd,
    StGetHi,
    StGetLo,
    StGetChk
  } state_e;

  function automatic logic mode_ok(input logic [2:0] m);
    return (m == MODE_555) || (m == MODE_SINE);
  endfunction

endpackage

// File: rtl/byte_timeout.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and flags expiry.
module byte_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = enable_i && (cnt_q == Limit);

endmodule

// File: rtl/uart_cmd_parser.sv
// Parses 5-byte framed UART commands (A5, CMD, P_HI, P_LO, CHK) into mode/factor updates.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter logic [15:0] FACTOR_RST     = 16'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [2:0]  mode,
  output logic [15:0] factor,
  output logic        flag,
  output logic        err,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [2:0]  mode_q, mode_d;
  logic [15:0] factor_q, factor_d;
  logic        flag_q, flag_d;
  logic        err_q, err_d;
  logic        upd_q, upd_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  lo_q, lo_d;
  logic        expired;

  byte_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_byte_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (rx_valid || (state_q == StIdle) || expired),
    .enable_i (state_q != StIdle),
    .expired_o(expired)
  );

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    factor_d = factor_q;
    cmd_d    = cmd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    err_d    = 1'b0;
    upd_d    = 1'b0;
    // flag trails the register update by one cycle
    flag_d   = upd_q;

    // Expiry beats a coincident byte; 0xA5 mid-frame is plain data.
    if (expired) begin
      state_d = StIdle;
      err_d   = 1'b1;
    end else if (rx_valid) begin
      unique case (state_q)
        StIdle: begin
          if (rx_data == HDR) state_d = StGetCmd;
        end
        StGetCmd: begin
          cmd_d   = rx_data;
          state_d = StGetHi;
        end
        StGetHi: begin
          hi_d    = rx_data;
          state_d = StGetLo;
        end
        StGetLo: begin
          lo_d    = rx_data;
          state_d = StGetChk;
        end
        StGetChk: begin
          state_d = StIdle;
          if (rx_data != (cmd_q ^ hi_q ^ lo_q)) begin
            err_d = 1'b1;
          end else if ((cmd_q == CMD_MODE) && mode_ok(lo_q[2:0])) begin
            mode_d = lo_q[2:0];
            upd_d  = 1'b1;
          end else if ((cmd_q == CMD_FACTOR) && ({hi_q, lo_q} != 16'd0)) begin
            factor_d = {hi_q, lo_q};
            upd_d    = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      mode_q   <= MODE_SINE;
      factor_q <= FACTOR_RST;
      flag_q   <= 1'b0;
      err_q    <= 1'b0;
      upd_q    <= 1'b0;
      cmd_q    <= 8'h00;
      hi_q     <= 8'h00;
      lo_q     <= 8'h00;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      factor_q <= factor_d;
      flag_q   <= flag_d;
      err_q    <= err_d;
      upd_q    <= upd_d;
      cmd_q    <= cmd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign mode   = mode_q;
  assign factor = factor_q;
  assign flag   = flag_q;
  assign err    = err_q;
  assign busy   = (state_q != StIdle);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser with a frame-level reference model checked every cycle.
module tb_uart_cmd_parser;

  localparam int unsigned TO = 20;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [2:0]  mode;
  logic [15:0] factor;
  logic        flag;
  logic        err;
  logic        busy;

  int n_vec  = 0;
  int n_fail = 0;

  uart_cmd_parser #(
    .TIMEOUT_CYCLES(TO),
    .FACTOR_RST    (16'd2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .mode    (mode),
    .factor  (factor),
    .flag    (flag),
    .err     (err),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collects frame bytes, decides the outcome once five are in.
  logic [7:0]  fbuf [5];
  int          nb = 0;
  int          gap = 0;
  logic [2:0]  m_mode = 3'b010;
  logic [15:0] m_factor = 16'd2;
  logic        m_flag = 1'b0;
  logic        m_err = 1'b0;
  logic        m_pend = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      nb = 0; gap = 0; m_mode = 3'b010; m_factor = 16'd2;
      m_flag = 1'b0; m_err = 1'b0; m_pend = 1'b0;
    end else begin
      m_flag = m_pend;
      m_pend = 1'b0;
      m_err  = 1'b0;
      if (nb > 0 && gap == TO - 1) begin
        nb = 0; gap = 0; m_err = 1'b1;
      end else if (rx_valid) begin
        if (nb > 0 || rx_data == 8'hA5) begin
          fbuf[nb] = rx_data;
          nb++;
          gap = 0;
        end
        if (nb == 5) begin
          nb = 0;
          if (fbuf[4] != (fbuf[1] ^ fbuf[2] ^ fbuf[3])) m_err = 1'b1;
          else if (fbuf[1] == 8'h01 && (fbuf[3][2:0] == 3'b001 || fbuf[3][2:0] == 3'b010)) begin
            m_mode = fbuf[3][2:0]; m_pend = 1'b1;
          end else if (fbuf[1] == 8'h02 && {fbuf[2], fbuf[3]} != 16'd0) begin
            m_factor = {fbuf[2], fbuf[3]}; m_pend = 1'b1;
          end else m_err = 1'b1;
        end
      end else if (nb > 0) begin
        gap++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("mode", mode, m_mode);
      chk("factor", factor, m_factor);
      chk("flag", flag, m_flag);
      chk("err", err, m_err);
      chk("busy", busy, nb > 0);
      chk("flag_err_excl", flag & err, 0);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l,
                            input logic [7:0] k);
    send_byte(8'hA5);
    send_byte(c);
    send_byte(h);
    send_byte(l);
    send_byte(k);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    idle(2);
    chk("rst_mode", mode, 3'b010);
    chk("rst_factor", factor, 16'd2);
    chk("rst_flag", flag, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
  endtask

  initial begin
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    do_reset();

    // Factor update and flag timing
    send_frame(8'h02, 8'h01, 8'h00, 8'h03);
    idle(1);
    chk("f0100_factor", factor, 16'h0100);
    chk("f0100_flag_early", flag, 0);
    idle(1);
    chk("f0100_flag", flag, 1);
    idle(2);

    // Mode 555, then invalid mode 5
    send_frame(8'h01, 8'h00, 8'h01, 8'h00);
    idle(1);
    chk("mode555", mode, 3'b001);
    idle(1);
    chk("mode555_flag", flag, 1);
    send_frame(8'h01, 8'h00, 8'h05, 8'h04);
    idle(1);
    chk("badmode_err", err, 1);
    chk("badmode_keep", mode, 3'b001);
    idle(2);

    // Zero factor and bad checksum
    do_reset();
    send_frame(8'h02, 8'h00, 8'h00, 8'h02);
    idle(1);
    chk("zero_err", err, 1);
    chk("zero_keep", factor, 16'd2);
    send_frame(8'h02, 8'h01, 8'h00, 8'hFF);
    idle(1);
    chk("chk_err", err, 1);
    chk("chk_keep", factor, 16'd2);
    // Unknown command
    send_frame(8'h07, 8'h00, 8'h00, 8'h07);
    idle(1);
    chk("badcmd_err", err, 1);
    idle(2);

    // Timeout after partial frame
    send_byte(8'hA5);
    send_byte(8'h02);
    idle(TO);
    chk("to_busy_before", busy, 1);
    idle(1);
    chk("to_err", err, 1);
    chk("to_busy", busy, 0);
    send_frame(8'h02, 8'h00, 8'h07, 8'h05);
    idle(1);
    chk("after_to_factor", factor, 16'h0007);
    idle(3);

    // Byte arriving on the expiry cycle is dropped
    send_byte(8'hA5);
    idle(TO - 1);
    send_byte(8'h02);
    idle(1);
    chk("race_err", err, 1);
    chk("race_busy", busy, 0);
    idle(2);

    // Back-to-back frames and 0xA5 as payload
    send_frame(8'h01, 8'h00, 8'h01, 8'h00);
    send_frame(8'h02, 8'h00, 8'h03, 8'h01);
    send_frame(8'h02, 8'hA5, 8'hA5, 8'h02);
    idle(1);
    chk("b2b_mode", mode, 3'b001);
    chk("a5data_factor", factor, 16'hA5A5);
    idle(3);

    // Reset mid-frame, then garbage before a frame
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h01);
    @(negedge clk);
    rst_n = 1'b0; rx_valid = 1'b0;
    idle(1);
    chk("midrst_mode", mode, 3'b010);
    chk("midrst_factor", factor, 16'd2);
    chk("midrst_flag", flag, 0);
    chk("midrst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    send_byte(8'h00);
    send_byte(8'hFF);
    send_frame(8'h01, 8'h00, 8'h02, 8'h03);
    idle(2);
    chk("garbage_flag", flag, 1);
    chk("garbage_mode", mode, 3'b010);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
